// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoded control bundle and ALU-op codes.
// Imported by the ID/EX register and the hazard/forwarding units.
package pipe_pkg;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t      CTRL_BUBBLE = '0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a load in EX whose rt is read by the ID instr.
// Ports: EX valid/memread/rt, ID valid/rs/rt/alusrc in; stall_req out.
module load_use_detect #(
  parameter int RW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_memread,
  input  logic [RW-1:0] ex_rt,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_alusrc,
  output logic          stall_req
);

  logic ex_load;
  logic rs_hit;
  logic rt_hit;

  assign ex_load = ex_valid & ex_memread & (ex_rt != '0);
  assign rs_hit  = (ex_rt == id_rs);
  // rt is only a source when the ALU's B operand is not the immediate
  assign rt_hit  = (ex_rt == id_rt) & ~id_alusrc;

  assign stall_req = ex_load & id_valid & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with embedded load-use bubble insertion.
// Ports: ID bundle in, EX bundle out, hold/flush controls, stall_req out.
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic          hold,
  input  logic          flush,
  input  logic [8:0]    id_ctrl,
  input  logic [DW-1:0] id_pcplus4,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic [DW-1:0] id_signext,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  output logic          ex_valid,
  output logic [8:0]    ex_ctrl,
  output logic [DW-1:0] ex_pcplus4,
  output logic [DW-1:0] ex_rdata1,
  output logic [DW-1:0] ex_rdata2,
  output logic [DW-1:0] ex_signext,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic          stall_req
);

  ctrl_t id_c;
  ctrl_t ex_c;
  logic  bubble;

  assign id_c    = ctrl_t'(id_ctrl);
  assign ex_ctrl = ex_c;

  load_use_detect #(
    .RW(RW)
  ) u_lud (
    .ex_valid  (ex_valid),
    .ex_memread(ex_c.memread),
    .ex_rt     (ex_rt),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_alusrc (id_c.alusrc),
    .stall_req (stall_req)
  );

  // flush beats hold so a squashed instr is never retained
  assign bubble = flush | (~hold & stall_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_c       <= CTRL_BUBBLE;
      ex_pcplus4 <= '0;
      ex_rdata1  <= '0;
      ex_rdata2  <= '0;
      ex_signext <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
    end else if (bubble) begin
      ex_valid   <= 1'b0;
      ex_c       <= CTRL_BUBBLE;
      ex_pcplus4 <= '0;
      ex_rdata1  <= '0;
      ex_rdata2  <= '0;
      ex_signext <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
    end else if (!hold) begin
      ex_valid   <= id_valid;
      ex_c       <= id_valid ? id_c : CTRL_BUBBLE;
      ex_pcplus4 <= id_pcplus4;
      ex_rdata1  <= id_rdata1;
      ex_rdata2  <= id_rdata2;
      ex_signext <= id_signext;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: vector table, async reset sequence,
// and randomized traffic against a behavioural pipeline-register model.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, hold, flush;
  logic [8:0]  id_ctrl;
  logic [31:0] id_pcplus4, id_rdata1, id_rdata2, id_signext;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_valid;
  logic [8:0]  ex_ctrl;
  logic [31:0] ex_pcplus4, ex_rdata1, ex_rdata2, ex_signext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        stall_req;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DW(32), .RW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .id_valid  (id_valid),
    .hold      (hold),
    .flush     (flush),
    .id_ctrl   (id_ctrl),
    .id_pcplus4(id_pcplus4),
    .id_rdata1 (id_rdata1),
    .id_rdata2 (id_rdata2),
    .id_signext(id_signext),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rd     (id_rd),
    .ex_valid  (ex_valid),
    .ex_ctrl   (ex_ctrl),
    .ex_pcplus4(ex_pcplus4),
    .ex_rdata1 (ex_rdata1),
    .ex_rdata2 (ex_rdata2),
    .ex_signext(ex_signext),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .ex_rd     (ex_rd),
    .stall_req (stall_req)
  );

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [152:0] dut_bundle();
    return {ex_valid, ex_ctrl, ex_pcplus4, ex_rdata1, ex_rdata2,
            ex_signext, ex_rs, ex_rt, ex_rd};
  endfunction

  typedef struct {
    logic        v, h, f;
    logic [8:0]  c;
    logic [4:0]  rs, rt;
    logic [31:0] r1, se;
    logic        es, ev;
    logic [8:0]  ec;
    logic [31:0] er1, ese;
  } vec_t;

  function automatic vec_t mk(logic v, logic h, logic f, logic [8:0] c,
                              logic [4:0] rs, logic [4:0] rt,
                              logic [31:0] r1, logic [31:0] se,
                              logic es, logic ev, logic [8:0] ec,
                              logic [31:0] er1, logic [31:0] ese);
    vec_t x;
    x.v = v; x.h = h; x.f = f; x.c = c; x.rs = rs; x.rt = rt;
    x.r1 = r1; x.se = se; x.es = es; x.ev = ev; x.ec = ec;
    x.er1 = er1; x.ese = ese;
    return x;
  endfunction

  // Behavioural model of the EX-side register contents
  logic        m_v;
  logic [8:0]  m_c;
  logic [31:0] m_pc, m_r1, m_r2, m_se;
  logic [4:0]  m_rs, m_rt, m_rd;

  // A load sitting in EX writes rt; the ID instr always reads rs and
  // reads rt unless its B operand is the immediate (alusrc = bit 2).
  function automatic logic model_hazard();
    logic load_in_ex, reads_rt, dep;
    load_in_ex = m_v && m_c[5] && (m_rt != 0);
    reads_rt   = !id_ctrl[2];
    dep        = (m_rt == id_rs) || (reads_rt && m_rt == id_rt);
    return id_valid && load_in_ex && dep;
  endfunction

  task automatic model_clear();
    m_v = 0; m_c = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_se = 0;
    m_rs = 0; m_rt = 0; m_rd = 0;
  endtask

  localparam logic [8:0] ADD  = 9'h10A;
  localparam logic [8:0] LW   = 9'h1A4;
  localparam logic [8:0] ADDI = 9'h104;

  vec_t vec[28];

  initial begin
    logic hz;
    logic [152:0] exp_b;

    vec[0]  = mk(1,0,0,ADD ,1,2,32'h11,32'h20, 0,1,ADD ,32'h11,32'h20);
    vec[1]  = mk(1,0,0,LW  ,4,8,32'h22,32'h4 , 0,1,LW  ,32'h22,32'h4 );
    vec[2]  = mk(1,0,0,ADD ,8,5,32'h33,32'h20, 1,0,0   ,0     ,0     );
    vec[3]  = mk(1,0,0,ADD ,8,5,32'h33,32'h20, 0,1,ADD ,32'h33,32'h20);
    vec[4]  = mk(1,0,0,LW  ,1,0,32'h44,32'h0 , 0,1,LW  ,32'h44,32'h0 );
    vec[5]  = mk(1,0,0,ADD ,0,0,32'h55,32'h20, 0,1,ADD ,32'h55,32'h20);
    vec[6]  = mk(1,0,0,LW  ,2,9,32'h66,32'h8 , 0,1,LW  ,32'h66,32'h8 );
    vec[7]  = mk(1,0,0,ADDI,3,9,32'h77,32'h10, 0,1,ADDI,32'h77,32'h10);
    vec[8]  = mk(1,0,0,LW  ,1,8,32'h88,32'h0 , 0,1,LW  ,32'h88,32'h0 );
    vec[9]  = mk(1,1,1,ADD ,8,5,32'h1 ,32'h20, 1,0,0   ,0     ,0     );
    vec[10] = mk(0,0,0,LW  ,8,8,32'h99,32'h5 , 0,0,0   ,32'h99,32'h5 );
    vec[11] = mk(1,0,0,ADD ,1,2,32'hDEADBEEF,32'h20,
                 0,1,ADD,32'hDEADBEEF,32'h20);
    for (int k = 0; k < 3; k++)
      vec[12+k] = mk(1,1,0,LW,2,3,32'h100+k,32'h30+k,
                     0,1,ADD,32'hDEADBEEF,32'h20);
    vec[15] = mk(1,0,0,LW  ,1,7,32'hA ,32'h0 , 0,1,LW  ,32'hA ,32'h0 );
    vec[16] = mk(1,1,0,ADD ,7,5,32'h33,32'h20, 1,1,LW  ,32'hA ,32'h0 );
    vec[17] = mk(1,1,0,ADD ,7,5,32'h33,32'h20, 1,1,LW  ,32'hA ,32'h0 );
    vec[18] = mk(1,0,0,ADD ,7,5,32'h33,32'h20, 1,0,0   ,0     ,0     );
    vec[19] = mk(1,0,0,ADD ,7,5,32'h33,32'h20, 0,1,ADD ,32'h33,32'h20);
    vec[20] = mk(1,0,0,LW  ,1,6,32'hB ,32'h0 , 0,1,LW  ,32'hB ,32'h0 );
    vec[21] = mk(1,0,0,LW  ,6,6,32'hC ,32'h4 , 1,0,0   ,0     ,0     );
    vec[22] = mk(1,0,0,LW  ,6,6,32'hC ,32'h4 , 0,1,LW  ,32'hC ,32'h4 );
    vec[23] = mk(1,0,0,ADD ,6,6,32'hD ,32'h20, 1,0,0   ,0     ,0     );
    vec[24] = mk(1,0,0,ADD ,6,6,32'hD ,32'h20, 0,1,ADD ,32'hD ,32'h20);
    vec[25] = mk(1,0,0,LW  ,1,3,32'hE ,32'h0 , 0,1,LW  ,32'hE ,32'h0 );
    vec[26] = mk(1,0,0,ADD ,1,3,32'hF ,32'h20, 1,0,0   ,0     ,0     );
    vec[27] = mk(1,0,0,ADD ,1,3,32'hF ,32'h20, 0,1,ADD ,32'hF ,32'h20);

    reset = 1; id_valid = 0; hold = 0; flush = 0; id_ctrl = 0;
    id_pcplus4 = 0; id_rdata1 = 0; id_rdata2 = 0; id_signext = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    #12;
    chk("reset_bundle", dut_bundle(), 153'd0);
    chk("reset_stall", stall_req, 0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      id_valid = vec[i].v; hold = vec[i].h; flush = vec[i].f;
      id_ctrl = vec[i].c; id_rs = vec[i].rs; id_rt = vec[i].rt;
      id_rdata1 = vec[i].r1; id_signext = vec[i].se;
      id_pcplus4 = 32'(i * 4); id_rdata2 = 32'(i); id_rd = 5'(i);
      #1 chk($sformatf("v%0d_stall", i), stall_req, vec[i].es);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), ex_valid, vec[i].ev);
      chk($sformatf("v%0d_ctrl", i), ex_ctrl, vec[i].ec);
      chk($sformatf("v%0d_rdata1", i), ex_rdata1, vec[i].er1);
      chk($sformatf("v%0d_signext", i), ex_signext, vec[i].ese);
    end

    // async reset between edges, then first edge loads normally
    @(negedge clk);
    hold = 0; flush = 0; id_valid = 1; id_ctrl = ADD;
    id_rs = 1; id_rt = 2; id_rd = 3; id_rdata1 = 32'h77;
    @(posedge clk);
    #1 chk("pre_reset_valid", ex_valid, 1);
    #2 reset = 1;
    #1 chk("async_reset_bundle", dut_bundle(), 153'd0);
    @(negedge clk);
    reset = 0; id_rdata1 = 32'h1234; id_signext = 32'h20;
    @(posedge clk);
    #1;
    chk("post_reset_valid", ex_valid, 1);
    chk("post_reset_rdata1", ex_rdata1, 32'h1234);
    chk("post_reset_ctrl", ex_ctrl, ADD);

    // randomized traffic against the model
    @(negedge clk);
    reset = 1;
    #2 reset = 0;
    model_clear();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      id_valid   = ($urandom_range(0, 9) < 8);
      hold       = ($urandom_range(0, 19) < 3);
      flush      = ($urandom_range(0, 19) < 2);
      id_ctrl    = 9'($urandom);
      if ($urandom_range(0, 2) == 0) id_ctrl[5] = 1'b1;
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_rd      = 5'($urandom);
      id_pcplus4 = $urandom;
      id_rdata1  = $urandom;
      id_rdata2  = $urandom;
      id_signext = $urandom;
      #1;
      hz = model_hazard();
      chk("rand_stall", stall_req, hz);
      @(posedge clk);
      if (flush || (!hold && hz)) begin
        model_clear();
      end else if (!hold) begin
        m_v = id_valid; m_c = id_valid ? id_ctrl : 9'h0;
        m_pc = id_pcplus4; m_r1 = id_rdata1; m_r2 = id_rdata2;
        m_se = id_signext; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      end
      #1;
      exp_b = {m_v, m_c, m_pc, m_r1, m_r2, m_se, m_rs, m_rt, m_rd};
      chk("rand_bundle", dut_bundle(), exp_b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between decode (ID) and execute (EX) of the 5-stage MIPS pipeline. Captures the decoded control bundle, including the 2-bit `aluop` consumed by the EX-stage ALU-control decoder. Also captures operands, the sign-extended immediate (whose low 6 bits carry the funct field) and register specifiers. Embeds load-use hazard detection: on a hazard it inserts a bubble into EX and asks the front end to hold PC and IF/ID.

## Interface
Parameters:
- `DW`, 32, datapath width (operands, immediate, PC+4)
- `RW`, 5, register-specifier width

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `id_valid`  in  1  ID stage holds a real instruction
- `hold`  in  1  global freeze (e.g. memory wait); register keeps contents
- `flush`  in  1  taken branch resolved; squash the instruction entering EX
- `id_ctrl`  in  9  {regwrite, memtoreg, branch, memread, memwrite, regdst, alusrc, aluop[1:0]}
- `id_pcplus4`, `id_rdata1`, `id_rdata2`, `id_signext`  in  DW each  PC+4, register operands, sign-extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  RW each  register specifiers
- `ex_valid`  out  1  EX holds a real instruction
- `ex_ctrl`  out  9  registered control bundle, same packing as `id_ctrl`
- `ex_pcplus4`, `ex_rdata1`, `ex_rdata2`, `ex_signext`  out  DW  registered data
- `ex_rs`, `ex_rt`, `ex_rd`  out  RW  registered specifiers
- `stall_req`  out  1  combinational; front end must not advance PC or IF/ID this cycle

## Operation
- Load-use hazard (combinational): `stall_req` = `ex_valid` & `ex_ctrl.memread` & `id_valid` & (`ex_rt` != 0) & (`ex_rt` == `id_rs` | (`ex_rt` == `id_rt` & ~`id_ctrl.alusrc`)).
- Next-state priority, highest first:
  - `reset`: all outputs 0.
  - `flush`: bubble. `ex_valid`=0 and `ex_ctrl`=0; data fields don't-care (implementation zeroes them).
  - `hold`: all registers keep their values. `stall_req` is still computed but has no effect.
  - `stall_req`: bubble, as for `flush`. ID contents are not captured; they reappear next cycle because the front end holds.
  - otherwise: load every field from ID; `ex_valid` <= `id_valid`; `ex_ctrl` <= `id_valid` ? `id_ctrl` : 0.
- Bubble: all control bits 0, so no regwrite or memwrite. `aluop`=00 makes the downstream ALU decoder select add.
- An invalid ID instruction never creates a hazard and never propagates nonzero control.

## Timing
- Latency: one cycle, from an ID value at edge N to the EX output after edge N.
- `stall_req` asserts in the same cycle the dependent instruction sits in ID. It lasts exactly one cycle per load unless `hold` intervenes, in which case it persists while the condition persists.
- `flush` and `stall_req` together: flush wins. Result is identical (a bubble) and the front end handles the redirect.
- `flush` and `hold` together: flush wins, so a squashed instruction is never retained.
- `reset` mid-operation clears immediately (asynchronous). The first edge after deassertion loads normally.
- Back-to-back loads to the same `rt` each stall once. `$0` targets never stall.

## Structure
- Shared package `pipe_pkg`:
  - `ctrl_t` packed struct (field order as `id_ctrl`)
  - `CTRL_BUBBLE` = '0
  - `ALUOP_ADD`=2'b00, `ALUOP_SUB`=2'b01, `ALUOP_RTYPE`=2'b10
- One sub-module, `load_use_detect`: the pure combinational `stall_req` equation, reused by the later forwarding unit bench.

## Test plan
- Normal flow: `id_valid`=1, `id_ctrl`=9'b1_0_0_0_0_1_0_10, `id_signext`=32'h20 (funct add) -> next cycle `ex_ctrl`=9'b100001010, `ex_signext`=32'h20, `ex_valid`=1.
- Load-use: EX holds lw with `ex_rt`=8; ID has add with `id_rs`=8 -> `stall_req`=1 that cycle, next `ex_valid`=0 and `ex_ctrl`=0. Following cycle the add loads and `stall_req`=0.
- No false stall:
  - lw `ex_rt`=0 with `id_rs`=0 -> `stall_req`=0
  - lw `ex_rt`=9 with ID addi (`alusrc`=1) `id_rt`=9, `id_rs`=3 -> `stall_req`=0
- Flush priority: `flush`=1, `hold`=1, valid ID instruction -> next `ex_valid`=0 and `ex_ctrl`=0.
- Hold: load `ex_rdata1`=32'hDEADBEEF, then `hold`=1 for 3 cycles with changing ID inputs -> output stays 32'hDEADBEEF throughout.
- Async reset: assert `reset` between edges while `ex_valid`=1 -> all outputs 0 before the next edge. On deassertion, the first edge loads ID.
